// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC lane accumulator.
package mac_pkg;

    localparam int LANE_W = 32;
    localparam int HALF_W = 16;

    localparam logic MODE_32 = 1'b1;
    localparam logic MODE_16 = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seg_add32.sv
// 32-bit segmented adder: one 32-bit lane, or two independent 16-bit halves.
module seg_add32
    import mac_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              mode,
    output logic [LANE_W-1:0] sum
);

    logic [HALF_W:0]   lo;
    logic [HALF_W-1:0] hi;
    logic              carry;

    // The carry out of the low half only crosses into the high half in 32-bit mode.
    always_comb begin
        lo    = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]};
        carry = lo[HALF_W] & (mode == MODE_32);
        hi    = a[LANE_W-1:HALF_W] + b[LANE_W-1:HALF_W] + {{(HALF_W-1){1'b0}}, carry};
        sum   = {hi, lo[HALF_W-1:0]};
    end

endmodule

// File: rtl/mac_lane_accumulator.sv
// Accumulates a group of partial-sum beats lane-wise and emits one result per group.
module mac_lane_accumulator
    import mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANE_W*LANES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W*LANES-1:0] out_data,
    output logic                    out_mode,
    output logic [CNT_W-1:0]        out_beats
);

    localparam int DW = LANE_W * LANES;

    state_t           state;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    sum;
    logic             acc_mode;
    logic [CNT_W-1:0] beats;
    logic             accept;

    assign accept = in_valid & in_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        seg_add32 u_add (
            .a    (acc[g*LANE_W +: LANE_W]),
            .b    (in_data[g*LANE_W +: LANE_W]),
            .mode (acc_mode),
            .sum  (sum[g*LANE_W +: LANE_W])
        );
    end

    // The accumulator register doubles as the result; it only leaves HOLD through a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            acc_mode  <= MODE_16;
            beats     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            beats     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc      <= in_data;
                        acc_mode <= mode;
                        beats    <= CNT_W'(1);
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= sum;
                        // Counter sticks at all-ones while lanes keep accumulating.
                        if (beats != {CNT_W{1'b1}}) begin
                            beats <= beats + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = acc;
    assign out_mode  = acc_mode;
    assign out_beats = beats;

endmodule

// File: tb/tb_mac_lane_accumulator.sv
// Directed self-checking bench for mac_lane_accumulator.
module tb_mac_lane_accumulator;

    localparam int LANES = 4;
    localparam int CNT_W = 8;
    localparam int DW    = 32 * LANES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_mode;
    logic [CNT_W-1:0] out_beats;

    int checks   = 0;
    int failures = 0;

    mac_lane_accumulator #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lanes4(input logic [31:0] l0, input logic [31:0] l1,
                                             input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat for exactly one rising edge, then idles the input.
    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 ||
            out_mode !== 1'b0 || out_beats !== '0) begin
            failures++;
            $display("[TB] FAIL reset_values: got v=%b r=%b d=%h m=%b b=%0d, expected all zero",
                     out_valid, in_ready, out_data, out_mode, out_beats);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic32();
        out_ready = 1'b1;
        send_beat(lanes4(1, 2, 3, 4), 1'b0, 1'b1);
        send_beat(lanes4(1, 2, 3, 4), 1'b0, 1'b1);
        send_beat(lanes4(1, 2, 3, 4), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== lanes4(3, 6, 9, 12)) begin
            failures++;
            $display("[TB] FAIL basic32_data: got v=%b d=%h expected v=1 d=%h",
                     out_valid, out_data, lanes4(3, 6, 9, 12));
        end
        checks++;
        if (out_beats !== 8'd3 || out_mode !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic32_beats: got b=%0d m=%b expected b=3 m=1", out_beats, out_mode);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic32_one_cycle: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_mode16();
        // Second beat flips mode high; the group must stay in the latched 16-bit mode.
        send_beat(lanes4(32'h0001_FFFF, 0, 0, 0), 1'b0, 1'b0);
        send_beat(lanes4(32'h0001_0001, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_data !== lanes4(32'h0002_0000, 0, 0, 0) || out_mode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mode16_nocarry: got d=%h m=%b expected d=%h m=0",
                     out_data, out_mode, lanes4(32'h0002_0000, 0, 0, 0));
        end
        tick();
        send_beat(lanes4(32'h0001_FFFF, 0, 0, 0), 1'b0, 1'b1);
        send_beat(lanes4(32'h0001_0001, 0, 0, 0), 1'b1, 1'b0);
        checks++;
        if (out_data !== lanes4(32'h0003_0000, 0, 0, 0) || out_mode !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mode32_carry: got d=%h m=%b expected d=%h m=1",
                     out_data, out_mode, lanes4(32'h0003_0000, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_wrap();
        send_beat(lanes4(32'hFFFF_FFFF, 0, 0, 32'h8000_0000), 1'b0, 1'b1);
        send_beat(lanes4(32'h0000_0002, 0, 0, 32'h8000_0000), 1'b1, 1'b1);
        checks++;
        if (out_data !== lanes4(32'h0000_0001, 0, 0, 0)) begin
            failures++;
            $display("[TB] FAIL wrap32: got %h expected %h", out_data, lanes4(32'h1, 0, 0, 0));
        end
        tick();
        send_beat(lanes4(0, 32'hFFFF_FFFF, 0, 0), 1'b0, 1'b0);
        send_beat(lanes4(0, 32'h0002_0002, 0, 0), 1'b1, 1'b0);
        checks++;
        if (out_data !== lanes4(0, 32'h0001_0001, 0, 0)) begin
            failures++;
            $display("[TB] FAIL wrap16: got %h expected %h", out_data, lanes4(0, 32'h0001_0001, 0, 0));
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp;
        exp = lanes4(32'h30, 0, 8, 0);
        out_ready = 1'b0;
        send_beat(lanes4(32'h10, 0, 7, 0), 1'b0, 1'b1);
        send_beat(lanes4(32'h20, 0, 1, 0), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_last = 1'b1; in_data = lanes4(32'hDEAD, 32'hBEEF, 1, 1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
                failures++;
                $display("[TB] FAIL hold_stable[%0d]: got v=%b r=%b d=%h expected v=1 r=0 d=%h",
                         i, out_valid, in_ready, out_data, exp);
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        send_beat(lanes4(1, 0, 0, 0), 1'b0, 1'b1);
        send_beat(lanes4(2, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_data !== lanes4(3, 0, 0, 0) || out_beats !== 8'd2) begin
            failures++;
            $display("[TB] FAIL after_hold_group: got d=%h b=%0d expected d=%h b=2",
                     out_data, out_beats, lanes4(3, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_clear();
        send_beat(lanes4(32'h11, 0, 0, 0), 1'b0, 1'b1);
        send_beat(lanes4(32'h22, 0, 0, 0), 1'b0, 1'b1);
        // Beat coinciding with clr must be dropped.
        clr = 1'b1;
        send_beat(lanes4(32'h100, 0, 0, 0), 1'b1, 1'b1);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clr_no_output[%0d]: got v=%b expected 0", i, out_valid);
            end
            tick();
        end
        send_beat(lanes4(32'h5, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== lanes4(32'h5, 0, 0, 0) || out_beats !== 8'd1) begin
            failures++;
            $display("[TB] FAIL clr_next_group: got v=%b d=%h b=%0d expected v=1 d=%h b=1",
                     out_valid, out_data, out_beats, lanes4(32'h5, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 259; i++) begin
            send_beat(lanes4(1, 0, 0, 0), 1'b0, 1'b1);
        end
        send_beat(lanes4(1, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_beats !== 8'hFF || out_data !== lanes4(32'd260, 0, 0, 0)) begin
            failures++;
            $display("[TB] FAIL beat_saturation: got b=%0d d=%h expected b=255 d=%h",
                     out_beats, out_data, lanes4(32'd260, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_beat(lanes4(32'hAB, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL areset_pre_hold: got v=%b expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 ||
            out_mode !== 1'b0 || out_beats !== '0) begin
            failures++;
            $display("[TB] FAIL areset_in_hold: got v=%b r=%b d=%h m=%b b=%0d expected all zero",
                     out_valid, in_ready, out_data, out_mode, out_beats);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        send_beat(lanes4(32'h7, 0, 0, 0), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== lanes4(32'h7, 0, 0, 0) || out_beats !== 8'd1) begin
            failures++;
            $display("[TB] FAIL areset_resume: got v=%b d=%h b=%0d expected v=1 d=%h b=1",
                     out_valid, out_data, out_beats, lanes4(32'h7, 0, 0, 0));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic32();
        test_mode16();
        test_wrap();
        test_backpressure();
        test_clear();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
